// File: rtl/t_using_d.sv
// Toggle flip-flop bank built from D flip-flops: each bit registers t ^ q.
// qb is the combinational complement of q, so it tracks q even during reset.

// Single-bit D register with asynchronous active-high reset.
module t_using_d_dff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  // Capture d on the rising edge; reset forces RST_VAL without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= RST_VAL;
    else     q <= d;
  end

endmodule

// Bank of WIDTH independent toggle bits.
module t_using_d #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic [WIDTH-1:0] t,
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb
);

  logic [WIDTH-1:0] d;

  // Toggle comes only from the XOR feedback into the D stage.
  always_comb begin
    d = t ^ q;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    t_using_d_dff #(
      .RST_VAL (RESET_VALUE[i])
    ) u_dff (
      .clk (clk),
      .rst (rst),
      .d   (d[i]),
      .q   (q[i])
    );
  end

  assign qb = ~q;

endmodule

// File: tb/tb_t_using_d.sv
// Self-checking bench for t_using_d: 1-bit default instance plus a 4-bit
// instance with a non-zero reset value. Expected q values are queued when
// t is driven and popped after the following rising edge.
module tb_t_using_d;

  logic       clk;
  logic       rst;
  logic       t;
  logic       q, qb;
  logic [3:0] t4;
  logic [3:0] q4, qb4;

  int checks = 0;
  int errors = 0;
  logic model_q;
  logic exp_q;
  logic exp_sb [$];

  t_using_d dut (
    .t   (t),
    .clk (clk),
    .rst (rst),
    .q   (q),
    .qb  (qb)
  );

  t_using_d #(
    .WIDTH       (4),
    .RESET_VALUE (4'b1010)
  ) dut4 (
    .t   (t4),
    .clk (clk),
    .rst (rst),
    .q   (q4),
    .qb  (qb4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Drive t at the falling edge, queue the expected q, compare after the rising edge.
  task automatic step(input logic tv, input logic qv, input string tag);
    @(negedge clk);
    t = tv;
    exp_sb.push_back(qv);
    @(posedge clk);
    #1;
    if (exp_sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      exp_q = exp_sb.pop_front();
      chk({tag, "_q"},  {31'b0, q},  {31'b0, exp_q});
      chk({tag, "_qb"}, {31'b0, qb}, {31'b0, ~exp_q});
    end
  endtask

  initial begin
    rst = 1'b1;
    t   = 1'bx;
    t4  = 4'b0000;
    #1;
    chk("rst_q_x_t", {31'b0, q},  32'd0);
    chk("rst_qb",    {31'b0, qb}, 32'd1);
    chk("rst_q4",    {28'b0, q4}, {28'b0, 4'b1010});
    #1 t = 1'b0;
    @(posedge clk); #1;
    chk("rst_edge_q",  {31'b0, q},  32'd0);
    chk("rst_edge_qb", {31'b0, qb}, 32'd1);

    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("hold_q",  {31'b0, q},  32'd0);
    chk("hold_qb", {31'b0, qb}, 32'd1);

    // Toggle sequence with fixed expected values.
    step(1'b1, 1'b1, "seq25");
    step(1'b0, 1'b1, "seq35");
    step(1'b1, 1'b0, "seq45");
    step(1'b1, 1'b1, "seq55");
    step(1'b0, 1'b1, "seq65");

    // Async reset between edges.
    #2 rst = 1'b1;
    #1;
    chk("async_q",  {31'b0, q},  32'd0);
    chk("async_qb", {31'b0, qb}, 32'd1);
    #1 rst = 1'b0;

    // Divide-by-2: q alternates and returns to 0.
    model_q = 1'b0;
    for (int i = 0; i < 8; i++) begin
      model_q = ~model_q;
      step(1'b1, model_q, $sformatf("div2_%0d", i));
    end
    chk("div2_end", {31'b0, q}, 32'd0);

    // Reset mid-toggle: q=1 with t=1, 3 ns reset pulse between edges.
    step(1'b1, 1'b1, "pre_mid");
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_q",  {31'b0, q},  32'd0);
    chk("mid_rst_qb", {31'b0, qb}, 32'd1);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rel_q", {31'b0, q}, 32'd1);

    // Reset rising together with clk while t=1 and q=0: reset wins.
    step(1'b1, 1'b0, "pre_sim");
    @(posedge clk);
    rst = 1'b1;
    #1;
    chk("sim_rst_q",  {31'b0, q},  32'd0);
    chk("sim_rst_qb", {31'b0, qb}, 32'd1);
    @(posedge clk); #1;
    chk("rst_held_q", {31'b0, q}, 32'd0);

    // Multi-bit instance: reset value then independent toggles.
    chk("w4_rst_q",  {28'b0, q4},  {28'b0, 4'b1010});
    chk("w4_rst_qb", {28'b0, qb4}, {28'b0, 4'b0101});
    @(negedge clk);
    rst = 1'b0;
    t   = 1'b0;
    t4  = 4'b0011;
    @(posedge clk); #1;
    chk("w4_tog_q",  {28'b0, q4},  {28'b0, 4'b1001});
    chk("w4_tog_qb", {28'b0, qb4}, {28'b0, 4'b0110});
    @(negedge clk);
    t4 = 4'b0000;
    @(posedge clk); #1;
    chk("w4_hold_q", {28'b0, q4}, {28'b0, 4'b1001});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
